// File: rtl/pulse_rate_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_rate_meter
//  Description : Counts synchronised rising edges of pulse_in over fixed
//                gate windows of GATE_CYCLES clocks. Reports the per-window
//                rate, a saturating running total and the number of
//                high-rate windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_rate_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int HI_THRESH   = 32,
  parameter int TOTAL_MAX   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clr,
  input  logic        pulse_in,
  output logic [15:0] rate,
  output logic        rate_valid,
  output logic [13:0] total,
  output logic        total_sat,
  output logic [15:0] hi_secs,
  output logic        busy
);

  localparam int            GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [15:0]   HI_LIM    = 16'(HI_THRESH);
  localparam logic [13:0]   TOT_MAX   = 14'(TOTAL_MAX);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync3;
  logic [GW-1:0] r_gate;
  logic [15:0]   r_wcount;

  logic          w_edge;
  logic          w_terminal;
  logic [15:0]   w_wcount_next;

  // Edge is the first cycle the synchronised input is seen high.
  assign w_edge        = r_sync2 & ~r_sync3;
  assign w_terminal    = (r_state == ST_MEASURE) && (r_gate == GATE_LAST);
  // Window count including this cycle's edge, saturating at 0xFFFF.
  assign w_wcount_next = (w_edge && (r_wcount != 16'hFFFF)) ? r_wcount + 16'd1 : r_wcount;

  assign busy      = (r_state == ST_MEASURE);
  assign total_sat = (total == TOT_MAX);

  // Two-flop synchroniser plus a delay flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= pulse_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start is a level; a low level in MEASURE always
  // returns to IDLE (after closing the window if it is the terminal cycle).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (start)  w_state_next = ST_MEASURE;
      ST_MEASURE: if (!start) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Gate/window counters, window close, running totals and clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate     <= '0;
      r_wcount   <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
      total      <= '0;
      hi_secs    <= '0;
    end else begin
      rate_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_gate   <= '0;
            r_wcount <= '0;
          end
        end
        ST_MEASURE: begin
          if (w_terminal) begin
            // Close the window even if start has just dropped.
            r_gate     <= '0;
            r_wcount   <= '0;
            rate       <= w_wcount_next;
            rate_valid <= 1'b1;
            if ((w_wcount_next > HI_LIM) && (hi_secs != 16'hFFFF)) begin
              hi_secs <= hi_secs + 16'd1;
            end
          end else if (!start) begin
            // Abort: the partial window is discarded.
            r_gate   <= '0;
            r_wcount <= '0;
          end else begin
            r_gate   <= r_gate + GW'(1);
            r_wcount <= w_wcount_next;
          end
        end
        default: begin
          r_gate   <= '0;
          r_wcount <= '0;
        end
      endcase

      if ((r_state == ST_MEASURE) && w_edge && (total != TOT_MAX)) begin
        total <= total + 14'd1;
      end

      // Clear wins over any same-cycle update; rate_valid is left alone.
      if (clr) begin
        rate     <= '0;
        total    <= '0;
        hi_secs  <= '0;
        r_wcount <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pulse_rate_meter.md
PULSE_RATE_METER -- requirements
Module: pulse_rate_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 100000000, meaning clk cycles per measurement window (1 s at 100 MHz).
REQ-002 SHALL have parameter HI_THRESH, default 32, meaning a window count strictly above this is a high-rate window.
REQ-003 SHALL have parameter TOTAL_MAX, default 9999, meaning the saturation value of the total count.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  level; 1 = measure, 0 = idle.
REQ-007 SHALL have port clr  input  1  synchronous clear of accumulated results.
REQ-008 SHALL have port pulse_in  input  1  pulse train to be measured; may be asynchronous to clk.
REQ-009 SHALL have port rate  output  16  rising edges counted in the last completed window.
REQ-010 SHALL have port rate_valid  output  1  one-cycle strobe when rate is updated.
REQ-011 SHALL have port total  output  14  rising edges counted since reset/clr, saturating.
REQ-012 SHALL have port total_sat  output  1  high while total == TOTAL_MAX.
REQ-013 SHALL have port hi_secs  output  16  completed windows with count > HI_THRESH, saturating at 0xFFFF.
REQ-014 SHALL have port busy  output  1  high while in MEASURE.

Function
REQ-015 SHALL pass pulse_in through a 2-flop synchronizer; a rising edge is detected when the second flop is 1 and a third (delay) flop is 0.
REQ-016 SHALL count a held-high pulse_in exactly once; pulse_in high for at least 1 cycle, then low for at least 1 cycle, SHALL count once.
REQ-017 SHALL implement FSM states IDLE and MEASURE.
REQ-018 SHALL transition IDLE -> MEASURE on the cycle after start is sampled 1, with gate counter = 0 and window count = 0.
REQ-019 SHALL, in MEASURE, increment the gate counter every cycle and the window count on every detected edge, saturating the window count at 0xFFFF.
REQ-020 SHALL, in the cycle with gate counter == GATE_CYCLES-1 (terminal cycle), include that cycle's edge in the closing window.
REQ-021 SHALL, on the next clk after the terminal cycle, load rate with the closing count and assert rate_valid for exactly 1 cycle.
REQ-022 SHALL, on that same next clk, reset the gate counter to 0 and the window count to 0, with no gap cycles between windows.
REQ-023 SHALL, on that same next clk, increment hi_secs if the closing count > HI_THRESH.
REQ-024 SHALL increment total on every detected edge in MEASURE, hold it at TOTAL_MAX, and ignore edges in IDLE.
REQ-025 SHALL, if start is sampled 0 in MEASURE, go to IDLE on the next clk, discard the partial window, not assert rate_valid, and hold rate, total and hi_secs.
REQ-026 SHALL close the window normally if start falls in the terminal cycle, then enter IDLE.
REQ-027 SHALL, on clr = 1, zero rate, total, hi_secs and the window count on the next clk, without changing the FSM state or gate counter.
REQ-028 SHALL give clr priority over any same-cycle window close or edge increment; rate_valid still pulses, with rate = 0.
REQ-029 SHALL keep rate_valid low in IDLE.

Reset
REQ-030 SHALL, while rst = 1, immediately (asynchronously) force rate, rate_valid, total, total_sat, hi_secs, busy, gate counter, window count and synchronizer flops to 0, with FSM = IDLE.
REQ-031 SHALL, after rst falls, stay in IDLE until start is sampled 1, including when rst falls mid-window.

Verification (GATE_CYCLES=10, HI_THRESH=2, TOTAL_MAX=5 unless stated)
REQ-032 Start at cycle 0, 3 clean pulses inside window 1 -> busy=1 from cycle 1; rate=3 with rate_valid high only in cycle 11; total=3.
REQ-033 Windows with 3 then 2 pulses -> hi_secs=1 after window 2; rate=2.
REQ-034 7 pulses over 2 windows -> total stops at 5, total_sat=1; rate values are unaffected by saturation.
REQ-035 start dropped at gate count 4 with 2 pulses seen -> no rate_valid; rate retains its prior value; busy=0 next cycle; restart yields a fresh 10-cycle window.
REQ-036 clr asserted in the terminal cycle of a 4-pulse window -> rate_valid pulses with rate=0; total=0; hi_secs=0.
REQ-037 rst asserted mid-window with pulse_in high -> all outputs 0 without waiting for a clk edge; no count on release until start.
